// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo_prog single-clock FIFO.
package sync_fifo_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic {STD = 1'b0, FWFT = 1'b1} fifo_mode_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port FIFO storage: one write port plus one registered read port
// whose load can bypass the write data (used as the FWFT head register).
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ld,
  input  logic                  byp,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately never reset or cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= byp ? wdata : mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with standard/FWFT read, programmable almost flags, flush
// and sticky error flags. Define SYNC_FIFO_ERR_CNT_EN to add ovf_cnt/udf_cnt.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 13,
  parameter int FWFT        = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  input  logic [DEPTH_WIDTH:0]   afull_thresh,
  input  logic [DEPTH_WIDTH:0]   aempty_thresh,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow
`ifdef SYNC_FIFO_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]   ovf_cnt,
  output logic [ERR_CNT_W-1:0]   udf_cnt
`endif
);

  localparam int PW = DEPTH_WIDTH + 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? sync_fifo_pkg::FWFT : sync_fifo_pkg::STD;

  logic [DEPTH_WIDTH:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic                   wa, ra;
  logic                   ld, byp;
  logic [DEPTH_WIDTH-1:0] raddr;

  // Acceptance uses registered flags only; flush masks both requests.
  assign wa = wr_en & ~wr_full & ~flush;
  assign ra = rd_en & ~rd_empty & ~flush;

  assign wr_ptr_nxt = wr_ptr + {{DEPTH_WIDTH{1'b0}}, wa};
  assign rd_ptr_nxt = rd_ptr + {{DEPTH_WIDTH{1'b0}}, ra};
  assign level_nxt  = water_level + {{DEPTH_WIDTH{1'b0}}, wa} - {{DEPTH_WIDTH{1'b0}}, ra};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      water_level  <= '0;
      wr_full      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      water_level  <= '0;
      wr_full      <= 1'b0;
      rd_empty     <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      water_level  <= level_nxt;
      wr_full      <= (wr_ptr_nxt[DEPTH_WIDTH] != rd_ptr_nxt[DEPTH_WIDTH]) &&
                      (wr_ptr_nxt[DEPTH_WIDTH-1:0] == rd_ptr_nxt[DEPTH_WIDTH-1:0]);
      rd_empty     <= (wr_ptr_nxt == rd_ptr_nxt);
      almost_full  <= (level_nxt >= afull_thresh);
      almost_empty <= (level_nxt <= aempty_thresh);
      overflow     <= overflow | (wr_en & wr_full);
      underflow    <= underflow | (rd_en & rd_empty);
    end
  end

`ifdef SYNC_FIFO_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (flush) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (wr_en && wr_full && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + ERR_CNT_W'(1);
      if (rd_en && rd_empty && !(&udf_cnt)) udf_cnt <= udf_cnt + ERR_CNT_W'(1);
    end
  end
`endif

  generate
    if (MODE == sync_fifo_pkg::FWFT) begin : g_fwft
      // Head register: refill from the next slot on a pop, or take the write
      // data directly when that slot is being written this very cycle.
      always_comb begin
        ld    = 1'b0;
        byp   = 1'b0;
        raddr = rd_ptr[DEPTH_WIDTH-1:0] + 1'b1;
        if (ra) begin
          if (water_level > PW'(1)) begin
            ld = 1'b1;
          end else if (wa) begin
            ld  = 1'b1;
            byp = 1'b1;
          end
        end else if (rd_empty && wa) begin
          ld  = 1'b1;
          byp = 1'b1;
        end
      end
    end else begin : g_std
      assign ld    = ra;
      assign byp   = 1'b0;
      assign raddr = rd_ptr[DEPTH_WIDTH-1:0];
    end
  endgenerate

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (2**DEPTH_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .we    (wa),
    .waddr (wr_ptr[DEPTH_WIDTH-1:0]),
    .wdata (wr_data),
    .ld    (ld),
    .byp   (byp),
    .raddr (raddr),
    .q     (rd_data)
  );

endmodule
